// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Write/read FSM state encodings and response codes.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_A,
        WR_HAVE_D,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_LSB_DEF = 2;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage with index decode, range check, write port
// and asynchronous read mux.
import axi_lite_pkg::*;

module axi_lite_reg_bank #(
    parameter int                   REG_WIDTH = 32,
    parameter int                   NUM_REGS  = 8,
    parameter int                   ADDR_LSB  = ADDR_LSB_DEF,
    parameter logic [REG_WIDTH-1:0] RESET_VAL = '0,
    localparam int                  IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic [REG_WIDTH-1:0]          waddr_i,
    input  logic [REG_WIDTH-1:0]          wdata_i,
    input  logic [REG_WIDTH-1:0]          raddr_i,
    output logic [REG_WIDTH-1:0]          rdata_o,
    output logic                          rok_o,
    output logic                          wok_o,
    output logic [IDX_W-1:0]              widx_o,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_o
);

    localparam logic [IDX_W:0] NREG = NUM_REGS[IDX_W:0];

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs_q;
    logic [IDX_W-1:0]                   ridx;
    logic                               unused_addr;

    // Upper address bits must be clear, else the access is out of range
    function automatic logic in_range(input logic [REG_WIDTH-1:0] a);
        logic [IDX_W:0] i;
        i = {1'b0, a[ADDR_LSB +: IDX_W]};
        return (i < NREG) && ((a >> (ADDR_LSB + IDX_W)) == '0);
    endfunction

    assign widx_o = waddr_i[ADDR_LSB +: IDX_W];
    assign ridx   = raddr_i[ADDR_LSB +: IDX_W];
    assign wok_o  = in_range(waddr_i);
    assign rok_o  = in_range(raddr_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q <= {NUM_REGS{RESET_VAL}};
        end else if (we_i && wok_o) begin
            regs_q[widx_o] <= wdata_i;
        end
    end

    assign rdata_o     = rok_o ? regs_q[ridx] : '0;
    assign regs_o      = regs_q;
    assign unused_addr = &{1'b0, waddr_i, raddr_i};

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with independent read/write FSMs over a register bank.
// Optional RRESP/BRESP ports enabled by defining AXIL_RESP_EN.
import axi_lite_pkg::*;

module axi_lite_slave_regs #(
    parameter int                   REG_WIDTH = 32,
    parameter int                   NUM_REGS  = 8,
    parameter int                   ADDR_LSB  = ADDR_LSB_DEF,
    parameter logic [REG_WIDTH-1:0] RESET_VAL = '0,
    localparam int                  IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [REG_WIDTH-1:0]          ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [REG_WIDTH-1:0]          RDATA,
    output logic                          RVALID,
    input  logic                          RREADY,
    input  logic [REG_WIDTH-1:0]          AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [REG_WIDTH-1:0]          WDATA,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic                          BVALID,
    input  logic                          BREADY,
`ifdef AXIL_RESP_EN
    output logic [1:0]                    RRESP,
    output logic [1:0]                    BRESP,
`endif
    output logic [NUM_REGS*REG_WIDTH-1:0] REGS_OUT,
    output logic                          WR_PULSE,
    output logic [IDX_W-1:0]              WR_IDX
);

    wr_state_t              wr_q, wr_d;
    rd_state_t              rd_q, rd_d;
    logic [REG_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]   rdata_q;
    logic                   wr_pulse_q;
    logic [IDX_W-1:0]       wr_idx_q;
    logic                   commit, ar_hs;
    logic [REG_WIDTH-1:0]   c_addr, c_data;
    logic [REG_WIDTH-1:0]   rd_data;
    logic                   rd_ok, wr_ok;
    logic [IDX_W-1:0]       wr_idx;

    axi_lite_reg_bank #(
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_LSB  (ADDR_LSB),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .we_i    (commit),
        .waddr_i (c_addr),
        .wdata_i (c_data),
        .raddr_i (ARADDR),
        .rdata_o (rd_data),
        .rok_o   (rd_ok),
        .wok_o   (wr_ok),
        .widx_o  (wr_idx),
        .regs_o  (REGS_OUT)
    );

    // Commit happens on whichever edge completes the second handshake
    always_comb begin
        wr_d     = wr_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        commit   = 1'b0;
        c_addr   = AWADDR;
        c_data   = WDATA;
        unique case (wr_q)
            WR_IDLE: begin
                if (AWVALID && WVALID) begin
                    commit = 1'b1;
                    wr_d   = WR_RESP;
                end else if (AWVALID) begin
                    awaddr_d = AWADDR;
                    wr_d     = WR_HAVE_A;
                end else if (WVALID) begin
                    wdata_d = WDATA;
                    wr_d    = WR_HAVE_D;
                end
            end
            WR_HAVE_A: begin
                c_addr = awaddr_q;
                if (WVALID) begin
                    commit = 1'b1;
                    wr_d   = WR_RESP;
                end
            end
            WR_HAVE_D: begin
                c_data = wdata_q;
                if (AWVALID) begin
                    commit = 1'b1;
                    wr_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) wr_d = WR_IDLE;
            end
            default: wr_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_d  = rd_q;
        ar_hs = 1'b0;
        unique case (rd_q)
            RD_IDLE: begin
                if (ARVALID) begin
                    ar_hs = 1'b1;
                    rd_d  = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RREADY) rd_d = RD_IDLE;
            end
            default: rd_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_q       <= WR_IDLE;
            rd_q       <= RD_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wr_pulse_q <= commit && wr_ok;
            if (commit && wr_ok) wr_idx_q <= wr_idx;
            if (ar_hs) rdata_q <= rd_data;
        end
    end

`ifdef AXIL_RESP_EN
    logic [1:0] rresp_q, bresp_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rresp_q <= RESP_OKAY;
            bresp_q <= RESP_OKAY;
        end else begin
            if (ar_hs) rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign RRESP = rresp_q;
    assign BRESP = bresp_q;
`else
    logic unused_rd_ok;
    assign unused_rd_ok = rd_ok;
`endif

    assign ARREADY  = (rd_q == RD_IDLE);
    assign RVALID   = (rd_q == RD_DATA);
    assign RDATA    = rdata_q;
    assign AWREADY  = (wr_q == WR_IDLE) || (wr_q == WR_HAVE_D);
    assign WREADY   = (wr_q == WR_IDLE) || (wr_q == WR_HAVE_A);
    assign BVALID   = (wr_q == WR_RESP);
    assign WR_PULSE = wr_pulse_q;
    assign WR_IDX   = wr_idx_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs.
// Expected pulses, responses and read data queued at stimulus time.
`timescale 1ns/1ps

module tb_axi_lite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [255:0] REGS_OUT;
    logic        WR_PULSE;
    logic [2:0]  WR_IDX;
`ifdef AXIL_RESP_EN
    logic [1:0]  RRESP, BRESP;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [8];
    int          wr_q [$];
    logic [1:0]  b_q [$];
    logic [31:0] rd_q [$];
    logic [1:0]  rr_q [$];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regs dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
`ifdef AXIL_RESP_EN
        .RRESP    (RRESP),
        .BRESP    (BRESP),
`endif
        .REGS_OUT (REGS_OUT),
        .WR_PULSE (WR_PULSE),
        .WR_IDX   (WR_IDX)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_word(input int i);
        return REGS_OUT[i*32 +: 32];
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a[31:5] == 0) ? model[a[4:2]] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a[31:5] == 0) ? 2'b00 : 2'b10;
    endfunction

    // Pulse, B and R outputs are matched against queued expectations
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (WR_PULSE) begin
                if (wr_q.size() == 0) begin
                    check("pulse_unexpected", {29'd0, WR_IDX}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_idx", {29'd0, WR_IDX}, wr_q.pop_front());
                    check("pulse_with_bvalid", BVALID, 1);
                end
            end
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", BVALID, 0);
                end else begin
`ifdef AXIL_RESP_EN
                    check("bresp", BRESP, b_q.pop_front());
`else
                    void'(b_q.pop_front());
`endif
                end
            end
            if (RVALID && RREADY) begin
                if (rd_q.size() == 0) begin
                    check("r_unexpected", RVALID, 0);
                end else begin
                    check("rdata", RDATA, rd_q.pop_front());
`ifdef AXIL_RESP_EN
                    check("rresp", RRESP, rr_q.pop_front());
`else
                    void'(rr_q.pop_front());
`endif
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        ARVALID = 1'b0;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        RREADY  = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_arready", ARREADY, 1);
        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 1);
        check("rst_rvalid", RVALID, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_pulse", WR_PULSE, 0);
        check("rst_rdata", RDATA, 0);
`ifdef AXIL_RESP_EN
        check("rst_rresp", RRESP, 0);
        check("rst_bresp", BRESP, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            check("rst_reg", reg_word(i), 0);
            model[i] = '0;
        end
        ARESETN = 1'b1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly);
        bit          ok, aw_done, w_done;
        int          idx, cyc;
        logic [31:0] old;
        ok  = (addr[31:5] == 0);
        idx = int'(addr[4:2]);
        old = model[idx];
        if (ok) begin
            wr_q.push_back(idx);
            model[idx] = data;
        end
        b_q.push_back(exp_resp(addr));
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(posedge ACLK); #1;
            if (aw_done || w_done) check("reg_hold", reg_word(idx), old);
            if (w_done && !aw_done) check("wready_low", WREADY, 0);
            if (aw_done && !w_done) check("awready_low", AWREADY, 0);
            AWVALID = !aw_done && (cyc >= aw_dly);
            AWADDR  = addr;
            WVALID  = !w_done && (cyc >= w_dly);
            WDATA   = data;
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            cyc++;
        end
        check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("reg_after", reg_word(idx), ok ? data : old);
        check("bvalid", BVALID, 1);
        @(posedge ACLK); #1;
        check("b_done", BVALID, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdy_dly,
                            input logic [31:0] exp, input logic [1:0] resp);
        @(posedge ACLK); #1;
        check("arready", ARREADY, 1);
        ARVALID = 1'b1;
        ARADDR  = addr;
        RREADY  = 1'b0;
        rd_q.push_back(exp);
        rr_q.push_back(resp);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            check("rvalid_hold", RVALID, 1);
            check("rdata_hold", RDATA, exp);
            check("arready_low", ARREADY, 0);
            @(posedge ACLK); #1;
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        check("r_done", RVALID, 0);
    endtask

    initial begin
        logic [31:0] a, d, e;
        do_reset();

        axi_write(32'h4, 32'hDEAD_BEEF, 0, 0);
        axi_write(32'h8, 32'h1234_5678, 3, 0);
        axi_write(32'h1C, 32'hA5A5_0007, 0, 2);
        axi_read(32'h4, 5, 32'hDEAD_BEEF, 2'b00);
        axi_read(32'h8, 0, 32'h1234_5678, 2'b00);
        axi_read(32'h1F, 1, 32'hA5A5_0007, 2'b00);

        axi_write(32'h40, 32'hBAD0_0040, 0, 0);
        axi_write(32'h20, 32'hBAD0_0020, 1, 0);
        axi_read(32'h40, 0, 32'h0, 2'b10);
        for (int i = 0; i < 8; i++) check("oor_no_change", reg_word(i), model[i]);

        for (int k = 0; k < 6; k++) begin
            a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            d = $urandom;
            axi_write(a, d, $urandom_range(0, 2), $urandom_range(0, 2));
            a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            axi_read(a, $urandom_range(0, 2), model_rd(a), 2'b00);
        end

        // Read sampling a register in its commit cycle sees the old value
        e = model_rd(32'h14);
        fork
            axi_write(32'h14, 32'h5555_AAAA, 0, 0);
            axi_read(32'h14, 1, e, 2'b00);
        join
        axi_read(32'h14, 0, 32'h5555_AAAA, 2'b00);

        // Reset while holding an address only: transaction is dropped
        @(posedge ACLK); #1;
        AWVALID = 1'b1;
        AWADDR  = 32'hC;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        check("have_a_awready", AWREADY, 0);
        check("have_a_wready", WREADY, 1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        check("mid_rst_awready", AWREADY, 1);
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_reg3", reg_word(3), 0);
        repeat (2) @(posedge ACLK);
        #1;
        check("mid_rst_no_b", BVALID, 0);
        axi_write(32'hC, 32'hC0FF_EE03, 0, 1);
        axi_read(32'hC, 2, 32'hC0FF_EE03, 2'b00);

        repeat (3) @(posedge ACLK);
        check("wr_q_empty", wr_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
